// File: rtl/uart_loader_pkg.sv
// uart_loader shared definitions: FSM state codes and default
// reply bytes for the UART image loader.
package uart_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LEN  = 3'd1;
  localparam state_t S_DATA = 3'd2;
  localparam state_t S_ACK  = 3'd3;
  localparam state_t S_NAK  = 3'd4;

  localparam logic [7:0] ACK_DEF = 8'hAA;
  localparam logic [7:0] NAK_DEF = 8'h55;

endpackage

// File: rtl/uart_loader_if.sv
// uart_loader bus bundle: rx FIFO read side, imem write port
// and the tx reply handshake.
interface uart_loader_if #(
  parameter int ADDR_W = 12
);

  logic              rx_empty;
  logic [7:0]        rx_dout;
  logic              rx_rd_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;

  modport master (
    input  rx_empty,
    input  rx_dout,
    input  tx_ready,
    output rx_rd_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output tx_valid,
    output tx_data
  );

  modport slave (
    output rx_empty,
    output rx_dout,
    output tx_ready,
    input  rx_rd_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  tx_valid,
    input  tx_data
  );

endinterface

// File: rtl/uart_word_asm.sv
// uart_word_asm: little-endian byte-to-word assembler with a
// pulse on the fourth byte of each word.
module uart_word_asm (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_vld
);

  logic [31:0] shreg;
  logic [1:0]  byte_cnt;

  // word is valid combinationally alongside the 4th pop
  assign word     = {din, shreg[31:8]};
  assign word_vld = pop && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (pop) begin
      shreg    <= word;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: pulls a length-prefixed LE word image out of the
// UART rx FIFO into imem, then answers with an ACK or NAK byte.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int         ADDR_W      = 12,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] ACK_BYTE    = ACK_DEF,
  parameter logic [7:0] NAK_BYTE    = NAK_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  uart_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

  state_t            state;
  logic [31:0]       len;
  logic [ADDR_W:0]   word_idx;
  logic [TW-1:0]     timer;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic        loading;
  logic        pop;
  logic        clr;
  logic        timeout;
  logic        idx_last;
  logic [31:0] word;
  logic        word_vld;

  assign loading  = (state == S_LEN) || (state == S_DATA);
  assign pop      = loading && !bus.rx_empty;
  assign clr      = (state == S_IDLE) && start;
  assign timeout  = loading && bus.rx_empty
                 && (timer == T_LAST);
  assign idx_last = 32'(word_idx) == (len - 32'd1);

  uart_word_asm u_asm (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .pop      (pop),
    .din      (bus.rx_dout),
    .word     (word),
    .word_vld (word_vld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      len      <= '0;
      word_idx <= '0;
      timer    <= '0;
      error    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (loading) timer <= pop ? '0 : timer + 1'b1;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (start) begin
            state    <= S_LEN;
            word_idx <= '0;
            timer    <= '0;
            error    <= 1'b0;
          end
        end
        (state == S_LEN): begin
          if (timeout) begin
            state <= S_NAK;
            error <= 1'b1;
          end else if (word_vld) begin
            len <= word;
            if (word == 32'd0) begin
              state <= S_ACK;
            end else if (word > MAX_LEN) begin
              state <= S_NAK;
              error <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        (state == S_DATA): begin
          if (timeout) begin
            state <= S_NAK;
            error <= 1'b1;
          end else if (word_vld) begin
            we_q     <= 1'b1;
            addr_q   <= word_idx[ADDR_W-1:0];
            wdata_q  <= word;
            word_idx <= word_idx + 1'b1;
            if (idx_last) state <= S_ACK;
          end
        end
        (state == S_ACK) || (state == S_NAK): begin
          if (bus.tx_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_rd_en  = pop;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.tx_valid  = (state == S_ACK) || (state == S_NAK);
  assign bus.tx_data   = (state == S_ACK) ? ACK_BYTE :
                         (state == S_NAK) ? NAK_BYTE : 8'h00;

  assign busy = (state != S_IDLE);
  assign done = (state == S_ACK) && bus.tx_ready;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed loads against a byte FIFO model with a
// scoreboard of expected imem writes.
module tb_uart_loader;

  localparam int AW = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic clk = 1'b0;
  logic rstn;
  logic start;
  logic busy;
  logic done;
  logic error;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;

  logic [7:0] fifo_mem [0:511];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   pop_n  = 0;
  logic we_due = 1'b0;
  wr_t  exp_q [$];

  uart_loader_if #(.ADDR_W(AW)) bif ();

  uart_loader #(
    .ADDR_W      (AW),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .bus   (bif.master),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  assign bif.rx_empty = (rd_ptr == wr_ptr);
  assign bif.rx_dout  = fifo_mem[rd_ptr[8:0]];

  // FIFO pop side plus the cycle a data write is due
  always @(posedge clk) begin
    if (!rstn) begin
      pop_n  <= 0;
      we_due <= 1'b0;
    end else begin
      if (bif.rx_rd_en) rd_ptr <= rd_ptr + 1;
      we_due <= bif.rx_rd_en && pop_n >= 7
             && (pop_n % 4) == 3;
      if (start && !busy) pop_n <= 0;
      else if (bif.rx_rd_en) pop_n <= pop_n + 1;
    end
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (bif.mem_we || we_due) begin
      chk("we_lat", 32'(bif.mem_we), 32'(we_due));
      if (bif.mem_we) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          chk("we_extra", 32'(bif.mem_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("waddr", 32'(bif.mem_addr), 32'(e.a));
          chk("wdata", bif.mem_wdata, e.d);
        end
      end
    end
  endtask

  task automatic push_byte(logic [7:0] b);
    fifo_mem[wr_ptr[8:0]] = b;
    wr_ptr++;
  endtask

  task automatic push_word(logic [31:0] w);
    for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_tx(string tag);
    for (int i = 0; i < 400 && !bif.tx_valid; i++) tick();
    chk(tag, 32'(bif.tx_valid), 32'd1);
  endtask

  task automatic handshake(logic [7:0] b, logic exp_done);
    chk("tx_data", 32'(bif.tx_data), 32'(b));
    bif.tx_ready = 1'b1;
    #1;
    chk("done_hs", 32'(done), 32'(exp_done));
    tick();
    bif.tx_ready = 1'b0;
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("txv_after", 32'(bif.tx_valid), 32'd0);
  endtask

  initial begin
    int w0;
    int c;
    rstn = 1'b0;
    start = 1'b0;
    bif.tx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_we", 32'(bif.mem_we), 32'd0);
    chk("rst_txv", 32'(bif.tx_valid), 32'd0);
    rstn = 1'b1;
    tick();

    // len=2, back-to-back bytes
    w0 = n_writes;
    pulse_start();
    chk("busy_ld", 32'(busy), 32'd1);
    push_word(32'd2);
    push_word(32'h03020100);
    push_word(32'h07060504);
    exp_q.push_back('{a: 4'd0, d: 32'h03020100});
    exp_q.push_back('{a: 4'd1, d: 32'h07060504});
    wait_tx("l2_txv");
    handshake(8'hAA, 1'b1);
    chk("l2_nwr", 32'(n_writes - w0), 32'd2);
    chk("l2_err", 32'(error), 32'd0);

    // len=0
    w0 = n_writes;
    pulse_start();
    push_word(32'd0);
    wait_tx("l0_txv");
    handshake(8'hAA, 1'b1);
    chk("l0_nwr", 32'(n_writes - w0), 32'd0);

    // len=17 exceeds 2**AW
    w0 = n_writes;
    pulse_start();
    push_word(32'd17);
    wait_tx("l17_txv");
    chk("l17_err", 32'(error), 32'd1);
    handshake(8'h55, 1'b0);
    chk("l17_err2", 32'(error), 32'd1);
    chk("l17_nwr", 32'(n_writes - w0), 32'd0);

    // len=16 fills memory; stray start and a slow tx_ready
    w0 = n_writes;
    pulse_start();
    chk("l16_errclr", 32'(error), 32'd0);
    push_word(32'd16);
    for (int i = 0; i < 16; i++) begin
      push_word(32'hA5000000 ^ (i * 32'h01010101));
      exp_q.push_back('{a: 4'(i),
        d: 32'hA5000000 ^ (i * 32'h01010101)});
    end
    repeat (10) tick();
    pulse_start();
    wait_tx("l16_txv");
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("hold_txv", 32'(bif.tx_valid), 32'd1);
      chk("hold_txd", 32'(bif.tx_data), 32'hAA);
      chk("hold_done", 32'(done), 32'd0);
    end
    handshake(8'hAA, 1'b1);
    chk("l16_nwr", 32'(n_writes - w0), 32'd16);
    chk("l16_q", exp_q.size(), 32'd0);

    // timeout after 2 data bytes
    w0 = n_writes;
    pulse_start();
    push_word(32'd3);
    push_byte(8'h11);
    push_byte(8'h22);
    for (int i = 0; i < 50 && rd_ptr != wr_ptr; i++) tick();
    c = 0;
    while (!bif.tx_valid && c < 300) begin
      tick();
      c++;
    end
    chk("to_cycles", 32'(c), 32'd100);
    chk("to_err", 32'(error), 32'd1);
    handshake(8'h55, 1'b0);
    chk("to_nwr", 32'(n_writes - w0), 32'd0);

    // reset mid-DATA after 5 of 8 words
    w0 = n_writes;
    pulse_start();
    chk("rs_errclr", 32'(error), 32'd0);
    push_word(32'd8);
    for (int i = 0; i < 5; i++) begin
      push_word(32'h10203040 + i);
      exp_q.push_back('{a: 4'(i), d: 32'h10203040 + i});
    end
    for (int i = 0; i < 100 && n_writes - w0 < 5; i++) tick();
    repeat (2) tick();
    chk("rs_busy0", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_we", 32'(bif.mem_we), 32'd0);
    chk("rs_txv", 32'(bif.tx_valid), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_rd", 32'(bif.rx_rd_en), 32'd0);
    repeat (3) tick();
    rstn = 1'b1;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bif.tx_valid || busy) c++;
    end
    chk("rs_quiet", 32'(c), 32'd0);
    chk("rs_nwr", 32'(n_writes - w0), 32'd5);
    chk("rs_q", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
